baud_generator: RTL
===================

BAUD_GENERATOR -- requirements
Module: baud_generator

Interface
REQ-001 The block SHALL have parameter DIV_WIDTH, default 16, meaning the width of the divisor and of the sub-counter.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, meaning os_tick pulses per output period; legal values are even and >= 2.
REQ-003 The block SHALL have parameter RESET_DIV, default 10, meaning the divisor after reset; legal range is 1..2^DIV_WIDTH-1.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit: high runs the generator, low holds it idle.
REQ-007 The block SHALL have port div_value, input, DIV_WIDTH bits: the new divisor, sampled when div_load is high.
REQ-008 The block SHALL have port div_load, input, 1 bit: a one-cycle request to load div_value.
REQ-009 The block SHALL have port div_ack, output, 1 bit: a one-cycle pulse in the cycle a new divisor takes effect.
REQ-010 The block SHALL have port div_err, output, 1 bit: a one-cycle pulse when div_load carries div_value = 0.
REQ-011 The block SHALL have port os_tick, output, 1 bit: a one-cycle strobe every D clock cycles.
REQ-012 The block SHALL have port tick, output, 1 bit: a one-cycle strobe at every OVERSAMPLE-th os_tick.
REQ-013 The block SHALL have port d_clock, output, 1 bit: a 50 %-duty divided clock with period D*OVERSAMPLE.

Function
REQ-014 The block SHALL hold an active divisor D, a pending divisor P with flag pend, a sub-counter 0..D-1 and an os-counter 0..OVERSAMPLE-1; all outputs SHALL be registered.
REQ-015 The block SHALL have two states: IDLE (enable = 0) and RUN (enable = 1), with the transition taken on the edge at which enable is sampled.
REQ-016 In IDLE, both counters, os_tick, tick and d_clock SHALL be 0.
REQ-017 In RUN, counting from the first edge at which enable is sampled high, os_tick SHALL be high in cycles D, 2D, 3D, ...
REQ-018 On each os_tick, the os-counter SHALL increment, wrapping from OVERSAMPLE-1 to 0.
REQ-019 d_clock SHALL start at 0 and toggle in the cycle of the (OVERSAMPLE/2)-th and the OVERSAMPLE-th os_tick of each period.
REQ-020 tick SHALL coincide with the OVERSAMPLE-th os_tick of each period (the d_clock falling edge); this cycle is the period boundary.
REQ-021 A div_load with div_value != 0 SHALL write P and set pend; a later load before application SHALL overwrite P, and the overwritten value is never acked.
REQ-022 A div_load with div_value = 0 SHALL pulse div_err in the next cycle and leave D, P and pend unchanged.
REQ-023 In RUN, a pending P SHALL be applied only at a period boundary: D <= P, pend cleared, div_ack high in the boundary cycle, and the next period uses the new D (glitch-free).
REQ-024 A div_load in the same cycle as a boundary SHALL NOT be applied at that boundary; it is applied at the next boundary.
REQ-025 In IDLE, a pending P SHALL be applied on the next edge, with div_ack high one cycle after the load.
REQ-026 When enable falls mid-period, the counters and outputs SHALL clear on the next edge with no tick; any pend SHALL then apply per REQ-025.
REQ-027 Counter arithmetic SHALL be DIV_WIDTH-bit unsigned with compare to D-1; with D = 1, os_tick SHALL be high every RUN cycle.

Reset
REQ-028 On reset high at a rising edge: D = RESET_DIV, P = 0, pend = 0, counters = 0, and all outputs (div_ack, div_err, os_tick, tick, d_clock) = 0.
REQ-029 Reset SHALL take priority over enable and div_load; a load pending at reset SHALL be discarded with no ack.

Verification (DIV_WIDTH = 8, OVERSAMPLE = 4, RESET_DIV = 3)
REQ-030 Reset, then enable = 1 from cycle 0 -> os_tick at 3, 6, 9, 12; d_clock rises at 6 and falls at 12; tick at 12 and 24.
REQ-031 In RUN, load 5 at cycle 4 -> D stays 3 until cycle 12; div_ack at 12; os_tick at 17, 22, 27, 32; tick at 32.
REQ-032 Load 0 at cycle 4 -> div_err at 5; os_tick and tick timing unchanged from REQ-030.
REQ-033 In RUN, load 7 at cycle 4, then enable = 0 at cycle 5 -> outputs 0 from 6; D = 7 with div_ack at 6; re-enable gives os_tick every 7 cycles.
REQ-034 Load 2 at cycle 12 (the boundary cycle) -> not applied at 12; div_ack at 24; os_tick every 2 cycles after 24.
REQ-035 Load 1, let it apply, then run -> os_tick high every cycle; d_clock period 4 cycles; reset mid-period clears all outputs next cycle with D = 3.

Source files
------------

// File: rtl/baud_generator.sv
// rtl/baud_generator.sv - programmable baud generator with oversample strobe, baud tick and 50% divided clock
// A new divisor is staged as pending and only swapped in at a period boundary (RUN) or immediately while idle.
module baud_generator #(
    parameter int DIV_WIDTH  = 16,
    parameter int OVERSAMPLE = 16,
    parameter int RESET_DIV  = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic                 div_load,
    output logic                 div_ack,
    output logic                 div_err,
    output logic                 os_tick,
    output logic                 tick,
    output logic                 d_clock
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]      OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]      OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(RESET_DIV);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    logic [DIV_WIDTH-1:0]  div_active;
    logic [DIV_WIDTH-1:0]  div_pend;
    logic                  pend;
    logic [DIV_WIDTH-1:0]  sub_cnt;
    logic [OS_W-1:0]       os_cnt;

    logic load_ok;
    logic sub_wrap;
    logic os_wrap;

    always_comb begin
        load_ok  = div_load && (div_value != '0);
        sub_wrap = (sub_cnt == div_active - DIV_WIDTH'(1));
        os_wrap  = (os_cnt == OS_LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            div_active <= DIV_RST;
            div_pend   <= '0;
            pend       <= 1'b0;
            sub_cnt    <= '0;
            os_cnt     <= '0;
            div_ack    <= 1'b0;
            div_err    <= 1'b0;
            os_tick    <= 1'b0;
            tick       <= 1'b0;
            d_clock    <= 1'b0;
        end else begin
            div_err <= div_load && (div_value == '0);
            div_ack <= 1'b0;
            os_tick <= 1'b0;
            tick    <= 1'b0;
            if (load_ok) begin
                div_pend <= div_value;
                pend     <= 1'b1;
            end
            if (!enable) begin
                state   <= IDLE;
                sub_cnt <= '0;
                os_cnt  <= '0;
                d_clock <= 1'b0;
                // Nothing is counting, so a divisor can be swapped in right away.
                if (load_ok) begin
                    div_active <= div_value;
                    pend       <= 1'b0;
                    div_ack    <= 1'b1;
                end else if (pend) begin
                    div_active <= div_pend;
                    pend       <= 1'b0;
                    div_ack    <= 1'b1;
                end
            end else if (state == IDLE) begin
                state   <= RUN;
                sub_cnt <= '0;
                os_cnt  <= '0;
                d_clock <= 1'b0;
            end else if (sub_wrap) begin
                sub_cnt <= '0;
                os_tick <= 1'b1;
                os_cnt  <= os_wrap ? '0 : os_cnt + OS_W'(1);
                if (os_wrap || os_cnt == OS_HALF)
                    d_clock <= ~d_clock;
                if (os_wrap) begin
                    tick <= 1'b1;
                    // Uses the pend flag from before this edge, so a load landing now waits a full period.
                    if (pend) begin
                        div_active <= div_pend;
                        pend       <= load_ok;
                        div_ack    <= 1'b1;
                    end
                end
            end else begin
                sub_cnt <= sub_cnt + DIV_WIDTH'(1);
            end
        end
    end

endmodule
